// File: rtl/tile_index_counter_pkg.sv
// Shared types and constants for the tile index counter.
// Holds the walk state encoding and the mode constants.
package tile_index_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_CONT   = 1'b1;

endpackage

// File: rtl/tile_index_counter_bounded_counter.sv
// Up-counter that runs from 0 to an inclusive limit and then wraps to 0.
// A synchronous clear overrides counting.
module bounded_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] value,
  output logic         at_limit
);

  logic [W-1:0] value_q, value_d;

  assign at_limit = (value_q == limit);
  assign value    = value_q;

  // NOTE: value_d gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (en) begin
      value_d = at_limit ? '0 : value_q + W'(1'b1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/tile_index_counter.sv
// Row-major 2-D index walker over a programmable tile, with stall, abort,
// single-pass and continuous modes.
module tile_index_counter
  import tile_index_counter_pkg::*;
#(
  parameter int COL_W = 2,
  parameter int ROW_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [COL_W-1:0] col_limit,
  input  logic [ROW_W-1:0] row_limit,
  input  logic             stall,
  input  logic             stop,
  output logic             busy,
  output logic             valid,
  output logic [COL_W-1:0] col_idx,
  output logic [ROW_W-1:0] row_idx,
  output logic             last,
  output logic             wrap,
  output logic             done
);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [COL_W-1:0] col_lim_q, col_lim_d;
  logic [ROW_W-1:0] row_lim_q, row_lim_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic in_run, step, abort, final_step;
  logic col_at_limit, row_at_limit;

  assign in_run     = (state_q == RUN);
  assign step       = in_run && !stall && !stop;
  assign abort      = in_run && stop;
  assign last       = in_run && col_at_limit && row_at_limit;
  assign final_step = step && last;

  // Both counters wrap to 0 by themselves on the final step; only an abort needs a clear.
  bounded_counter #(.W(COL_W)) u_col (
    .clk      (clk),
    .reset    (reset),
    .clear    (abort),
    .en       (step),
    .limit    (col_lim_q),
    .value    (col_idx),
    .at_limit (col_at_limit)
  );

  bounded_counter #(.W(ROW_W)) u_row (
    .clk      (clk),
    .reset    (reset),
    .clear    (abort),
    .en       (step && col_at_limit),
    .limit    (row_lim_q),
    .value    (row_idx),
    .at_limit (row_at_limit)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    col_lim_d = col_lim_q;
    row_lim_d = row_lim_q;
    wrap_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          mode_d    = mode;
          col_lim_d = col_limit;
          row_lim_d = row_limit;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (final_step) begin
          if (mode_q == MODE_SINGLE) state_d = DONE;
          else                       wrap_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      mode_q    <= MODE_SINGLE;
      col_lim_q <= '0;
      row_lim_q <= '0;
      wrap_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      col_lim_q <= col_lim_d;
      row_lim_q <= row_lim_d;
      wrap_q    <= wrap_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;
  assign done  = done_q;

endmodule

// File: tb/tb_tile_index_counter.sv
// Self-checking bench for tile_index_counter: directed scenarios plus random
// stimulus, compared each cycle against a position-based reference model.
module tb_tile_index_counter;

  localparam int COL_W = 2;
  localparam int ROW_W = 2;
  localparam int PW    = COL_W + ROW_W + 5;
  localparam int CM    = (1 << COL_W) - 1;
  localparam int RM    = (1 << ROW_W) - 1;

  logic             clk;
  logic             reset;
  logic             start;
  logic             mode;
  logic [COL_W-1:0] col_limit;
  logic [ROW_W-1:0] row_limit;
  logic             stall;
  logic             stop;
  logic             busy;
  logic             valid;
  logic [COL_W-1:0] col_idx;
  logic [ROW_W-1:0] row_idx;
  logic             last;
  logic             wrap;
  logic             done;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 walking, 2 done; m_p is the linear step number in the tile.
  int m_phase = 0;
  int m_p     = 0;
  int m_cl    = 0;
  int m_rl    = 0;
  bit m_mode  = 0;
  bit m_wrap  = 0;

  tile_index_counter #(.COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .col_limit (col_limit),
    .row_limit (row_limit),
    .stall     (stall),
    .stop      (stop),
    .busy      (busy),
    .valid     (valid),
    .col_idx   (col_idx),
    .row_idx   (row_idx),
    .last      (last),
    .wrap      (wrap),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tile_k();
    return (m_cl + 1) * (m_rl + 1);
  endfunction

  function automatic logic [PW-1:0] exp_vec();
    logic v;
    v = (m_phase == 1);
    return {(m_phase != 0), v, COL_W'(m_p % (m_cl + 1)), ROW_W'(m_p / (m_cl + 1)),
            v && (m_p == tile_k() - 1), m_wrap, (m_phase == 2)};
  endfunction

  function automatic logic [PW-1:0] dut_vec();
    return {busy, valid, col_idx, row_idx, last, wrap, done};
  endfunction

  // Drives one cycle of inputs, advances the model across the edge, and returns #1 after it.
  task automatic step(input bit st, input bit md, input int cl, input int rl,
                      input bit sl, input bit sp, input bit rn);
    start     = st;
    mode      = md;
    col_limit = COL_W'(cl);
    row_limit = ROW_W'(rl);
    stall     = sl;
    stop      = sp;
    reset     = rn;
    @(posedge clk);
    if (!rn) begin
      m_phase = 0; m_p = 0; m_cl = 0; m_rl = 0; m_mode = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      case (m_phase)
        0: if (st) begin
          m_phase = 1; m_p = 0; m_cl = cl & CM; m_rl = rl & RM; m_mode = md;
        end
        1: if (sp) begin
          m_phase = 0; m_p = 0;
        end else if (!sl) begin
          if (m_p == tile_k() - 1) begin
            m_p = 0;
            if (m_mode) m_wrap = 1;
            else        m_phase = 2;
          end else begin
            m_p++;
          end
        end
        default: m_phase = 0;
      endcase
    end
    #1;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec() || dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_single_pass();
    int seq_c[$];
    int seq_r[$];
    int exp_c[6] = '{0, 1, 2, 0, 1, 2};
    int exp_r[6] = '{0, 0, 0, 1, 1, 1};
    int last_at = -1;
    int done_at = -1;
    int busy_end = -1;
    step(1, 0, 2, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) idle_step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_pass cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (valid) begin seq_c.push_back(int'(col_idx)); seq_r.push_back(int'(row_idx)); end
      if (last) last_at = i;
      if (done) done_at = i;
      if (!busy && busy_end < 0) busy_end = i;
    end
    checks++;
    if (seq_c.size() != 6) begin
      errors++;
      $display("FAIL single_pass_len: got %0d want 6", seq_c.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seq_c[i] != exp_c[i] || seq_r[i] != exp_r[i]) begin
          errors++;
          $display("FAIL single_pass_seq%0d: got (%0d,%0d) want (%0d,%0d)",
                   i, seq_c[i], seq_r[i], exp_c[i], exp_r[i]);
        end
      end
    end
    checks++;
    if (last_at != 5 || done_at != 6 || busy_end != 7) begin
      errors++;
      $display("FAIL single_pass_timing: got last@%0d done@%0d idle@%0d want 5 6 7",
               last_at, done_at, busy_end);
    end
  endtask

  task automatic test_stall();
    int n_valid = 0;
    int n_done  = 0;
    int n_10    = 0;
    step(1, 0, 2, 1, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step(0, 0, 0, 0, (i >= 2 && i <= 4), 0, 1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stall cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (valid) n_valid++;
      if (valid && col_idx == 1 && row_idx == 0) n_10++;
      if (done) n_done++;
    end
    checks++;
    if (n_valid != 9 || n_done != 1 || n_10 != 4) begin
      errors++;
      $display("FAIL stall_counts: got valid=%0d done=%0d held=%0d want 9 1 4", n_valid, n_done, n_10);
    end
  endtask

  task automatic test_degenerate();
    step(1, 0, 0, 0, 0, 0, 1);
    checks++;
    if (dut_vec() !== exp_vec() || !last || !valid) begin
      errors++;
      $display("FAIL degen_00_first: got %b want %b", dut_vec(), exp_vec());
    end
    idle_step();
    checks++;
    if (dut_vec() !== exp_vec() || !done) begin
      errors++;
      $display("FAIL degen_00_done: got %b want %b", dut_vec(), exp_vec());
    end
    idle_step();
    step(1, 0, 3, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) idle_step();
      checks++;
      if (dut_vec() !== exp_vec() || row_idx !== '0) begin
        errors++;
        $display("FAIL degen_30 cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_continuous();
    int n_wrap = 0;
    int n_done = 0;
    step(1, 1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 14; i++) begin
      if (i > 0) idle_step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL continuous cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (wrap) n_wrap++;
      if (done) n_done++;
    end
    checks++;
    if (n_wrap != 3 || n_done != 0 || col_idx != 1 || row_idx != 0) begin
      errors++;
      $display("FAIL continuous_counts: got wrap=%0d done=%0d at (%0d,%0d) want 3 0 (1,0)",
               n_wrap, n_done, col_idx, row_idx);
    end
    step(0, 0, 0, 0, 1, 1, 1);
    checks++;
    if (dut_vec() !== exp_vec() || dut_vec() !== '0) begin
      errors++;
      $display("FAIL stop_abort: got %b want %b", dut_vec(), exp_vec());
    end
    idle_step();
    checks++;
    if (dut_vec() !== exp_vec() || done) begin
      errors++;
      $display("FAIL stop_no_done: got %b want %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_midwalk();
    step(1, 0, 2, 1, 0, 0, 1);
    idle_step();
    idle_step();
    checks++;
    if (col_idx !== 2'd2 || row_idx !== 2'd0 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL midwalk_pos: got %b want %b", dut_vec(), exp_vec());
    end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec() || dut_vec() !== '0) begin
      errors++;
      $display("FAIL midwalk_reset: got %b want %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_ignored_inputs();
    int n_valid = 0;
    int n_done  = 0;
    step(1, 0, 2, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step(1, 1, 3, 3, 0, 0, 1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ignore_inputs cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (valid) n_valid++;
      if (done) n_done++;
      if (!busy) break;
    end
    checks++;
    if (n_valid != 6 || n_done != 1) begin
      errors++;
      $display("FAIL ignore_counts: got valid=%0d done=%0d want 6 1", n_valid, n_done);
    end
    idle_step();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(3) == 0), $urandom_range(1), int'($urandom_range(CM)),
           int'($urandom_range(RM)), ($urandom_range(3) == 0), ($urandom_range(15) == 0),
           ($urandom_range(63) != 0));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        if (bad < 10) $display("FAIL random cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
        bad++;
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; stall = 1'b0; stop = 1'b0;
    col_limit = '0; row_limit = '0;
    test_reset();
    test_single_pass();
    test_stall();
    test_degenerate();
    test_continuous();
    test_reset_midwalk();
    test_ignored_inputs();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_index_counter.md
# tile_index_counter

Parametrised two-dimensional index generator for the SISD datapath. It walks column and row indices over a programmable tile, with separate column and row bounds. It supports stall, abort and a single-pass or continuous mode, and reports each step with a valid strobe. Instruction sequencing uses it to drive register-file and memory column/row addressing. It generalises the fixed 2-bit free-running column counter.

## Interface
- COL_W, 2, width of column index and column limit
- ROW_W, 2, width of row index and row limit
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset; clock clk
- start  in  1  request a new walk; sampled only in IDLE
- mode  in  1  0 = single pass, 1 = continuous; latched with start
- col_limit  in  COL_W  last column index (inclusive); latched with start
- row_limit  in  ROW_W  last row index (inclusive); latched with start
- stall  in  1  hold current indices while high in RUN
- stop  in  1  abort the walk from RUN
- busy  out  1  high in RUN and DONE
- valid  out  1  current col_idx/row_idx is a live step
- col_idx  out  COL_W  current column index
- row_idx  out  ROW_W  current row index
- last  out  1  current step is the final index of the tile (col_idx==col_limit && row_idx==row_limit && valid)
- wrap  out  1  one-cycle pulse on a continuous-mode wrap back to (0,0)
- done  out  1  one-cycle pulse on completion of a single pass

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - Indices held at 0; valid=0.
  - start=1 latches mode, col_limit and row_limit, then moves to RUN.
- RUN
  - valid=1.
  - Stepping a tile of (col_limit+1)*(row_limit+1) steps, row-major.
  - A step advances on each cycle with stall=0 and stop=0.
    - col_idx<lim_c: col_idx+1.
    - col_idx==lim_c: col_idx returns to 0 and row_idx increments.
  - Final step advancing (last=1, stall=0):
    - mode 0 → state DONE, indices cleared to 0.
    - mode 1 → indices to (0,0), wrap=1 for one cycle, stay in RUN.
- DONE: done=1, valid=0, busy=1 for exactly one cycle, then IDLE.
- stop=1 in RUN
  - Next state IDLE, indices to 0, no done or wrap pulse.
  - stop has priority over stall and over last.
- Ignored inputs
  - start is ignored outside IDLE.
  - stall and stop are ignored outside RUN.
  - Input limit changes during RUN are ignored; the latched copies are used.
- Limits of 0 are legal.
  - col_limit=0 gives a one-column walk.
  - Both 0 gives a single step: last=1 on the first RUN cycle.
- Indices never exceed the latched limits. All arithmetic is unsigned modulo field width; a limit at all-ones wraps naturally.

## Timing
- Reset at the next clk edge with reset=0 (any state, including mid-walk):
  - State IDLE.
  - busy=0, valid=0, col_idx=0, row_idx=0, last=0, wrap=0, done=0.
  - Latched mode and limits cleared to 0.
- Start latency: start is sampled at edge N; first valid step (0,0) is visible after edge N; busy rises in the same cycle.
- One index step per unstalled RUN cycle. A stalled cycle repeats the identical indices with valid=1.
- A single pass of K steps with no stalls:
  - valid high for K cycles, then done high in cycle K+1.
  - IDLE after that; a new start is accepted in the following cycle.
- Outputs
  - Registered: busy, valid, col_idx, row_idx, wrap, done.
  - Combinational: last, from registered indices and latched limits only.
- A wrap pulse coincides with the (0,0) step that follows the final step.

## Structure
- Package tile_index_counter_pkg:
  - state enum typedef {IDLE, RUN, DONE}
  - mode constants MODE_SINGLE=1'b0, MODE_CONT=1'b1
- Sub-module bounded_counter (parameter W):
  - Ports: clk, reset, clear, en, limit; outputs value and at_limit.
  - Increments on en, returns to 0 on en && at_limit, clears on clear.
  - Instantiated twice: column with en=step; row with en=step&&col_at_limit.
- Top level holds the FSM, the limit/mode latches and the pulse generation.

## Test plan
- Single pass, COL_W=ROW_W=2, limits col=2 row=1, mode 0:
  - valid for 6 cycles with (col,row) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - last only on (2,1); done pulse the next cycle; busy falls after.
- Stall: same setup, stall high for 3 cycles at (1,0) → (1,0) held for 4 valid cycles; total walk 9 valid cycles; done once.
- Degenerate: limits 0/0 → one valid cycle at (0,0) with last=1, then done; limits 3/0 → (0..3,0), row_idx stays 0.
- Continuous: limits 1/1, mode 1 → sequence repeats (0,0),(1,0),(0,1),(1,1) with wrap on each return to (0,0); no done. stop asserted at (1,0) together with stall → next cycle IDLE, indices 0, no done.
- Reset and start handling:
  - reset=0 at (2,0) of a 3x2 walk → next cycle all outputs 0, state IDLE.
  - start pulses during RUN and DONE are ignored.
  - Limit inputs changed mid-walk do not alter the sequence.
